// File: rtl/flash_seq.sv
// Sector update sequencer: erase, program and read back one page range through a
// command-level flash transaction port, reporting pass/fail and the mismatch count.
module flash_seq #(
  parameter int GAP_CYC     = 4,
  parameter int POLL_MAX    = 20000,
  parameter int TXN_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [23:0] base_addr,
  input  logic [7:0]  seed,
  input  logic [7:0]  len,
  output logic        flash_start,
  output logic [7:0]  cmd,
  output logic [23:0] addr,
  output logic [7:0]  write_data,
  output logic [7:0]  data_num,
  input  logic        flash_done,
  input  logic        rd_valid,
  input  logic [7:0]  read_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_code,
  output logic [7:0]  mismatch_cnt,
  output logic [3:0]  dbg_state
);

  // Transaction handshake: flash_start is a one-cycle request; the command fields
  // stay frozen until the matching flash_done pulse. GAP_CYC is expected to be >= 1.
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WREN1, S_ERASE, S_POLL1,
    S_WREN2, S_PROG, S_POLL2, S_VERIFY, S_FINISH
  } state_t;

  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);
  localparam logic [31:0] WDOG_LAST = 32'(TXN_TIMEOUT - 1);

  state_t      state;
  state_t      issue_state;
  logic [23:0] base_q;
  logic [7:0]  seed_q, len_q;
  logic        outstanding, in_gap;
  logic [15:0] gap_cnt, poll_cnt;
  logic [31:0] wdog;
  logic [7:0]  status_q, rx_cnt;

  logic        wip, range_bad, rx_take, mm_hit;
  logic [7:0]  rx_next, mm_next, final_mm;
  logic [8:0]  end_sum;
  logic [7:0]  i_cmd, i_wd, i_dn;
  logic [23:0] i_addr;

  assign dbg_state = state;

  always_comb begin
    wip       = rd_valid ? read_data[0] : status_q[0];
    range_bad = (len_q == 8'd0) || (({1'b0, base_q[7:0]} + {1'b0, len_q}) > 9'd256);
    rx_take   = (state == S_VERIFY) && outstanding && rd_valid && (rx_cnt < len_q);
    mm_hit    = rx_take && (read_data != seed_q);
    rx_next   = rx_cnt + {7'd0, rx_take};
    mm_next   = (mm_hit && mismatch_cnt != 8'hFF) ? mismatch_cnt + 8'd1 : mismatch_cnt;
    // Bytes never delivered by the end of the read count as mismatches too.
    end_sum   = {1'b0, mm_next} + {1'b0, len_q - rx_next};
    final_mm  = end_sum[8] ? 8'hFF : end_sum[7:0];
  end

  always_comb begin
    issue_state = (state == S_CHECK) ? S_WREN1 : state;
    i_cmd  = 8'h06;
    i_addr = 24'd0;
    i_wd   = 8'd0;
    i_dn   = 8'd0;
    case (issue_state)
      S_ERASE:          begin i_cmd = 8'h20; i_addr = base_q & 24'hFFF000; end
      S_POLL1, S_POLL2: begin i_cmd = 8'h05; i_dn = 8'd1; end
      S_PROG:           begin i_cmd = 8'h02; i_addr = base_q; i_dn = len_q; i_wd = seed_q; end
      S_VERIFY:         begin i_cmd = 8'h03; i_addr = base_q; i_dn = len_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      flash_start  <= 1'b0;
      cmd          <= 8'd0;
      addr         <= 24'd0;
      write_data   <= 8'd0;
      data_num     <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_code     <= 3'd0;
      mismatch_cnt <= 8'd0;
      base_q       <= 24'd0;
      seed_q       <= 8'd0;
      len_q        <= 8'd0;
      outstanding  <= 1'b0;
      in_gap       <= 1'b0;
      gap_cnt      <= 16'd0;
      poll_cnt     <= 16'd0;
      wdog         <= 32'd0;
      status_q     <= 8'd0;
      rx_cnt       <= 8'd0;
    end else begin
      flash_start <= 1'b0;
      done        <= 1'b0;
      if (state == S_VERIFY) begin
        rx_cnt       <= rx_next;
        mismatch_cnt <= mm_next;
      end
      if ((state == S_POLL1 || state == S_POLL2) && outstanding && rd_valid)
        status_q <= read_data;

      case (state)
        S_IDLE: begin
          if (req) begin
            base_q       <= base_addr;
            seed_q       <= seed;
            len_q        <= len;
            busy         <= 1'b1;
            pass         <= 1'b0;
            err_code     <= 3'd0;
            mismatch_cnt <= 8'd0;
            state        <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (range_bad) begin
            err_code <= 3'd1;
            state    <= S_FINISH;
          end else begin
            flash_start <= 1'b1;
            cmd         <= i_cmd;
            addr        <= i_addr;
            write_data  <= i_wd;
            data_num    <= i_dn;
            outstanding <= 1'b1;
            wdog        <= 32'd0;
            state       <= S_WREN1;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_code == 3'd0);
          state <= S_IDLE;
        end
        default: begin
          if (in_gap) begin
            if (gap_cnt == GAP_LAST) begin
              flash_start <= 1'b1;
              cmd         <= i_cmd;
              addr        <= i_addr;
              write_data  <= i_wd;
              data_num    <= i_dn;
              outstanding <= 1'b1;
              in_gap      <= 1'b0;
              wdog        <= 32'd0;
              status_q    <= 8'hFF;  // a poll that returns no byte is treated as busy
              rx_cnt      <= 8'd0;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end else if (outstanding) begin
            if (flash_done) begin
              outstanding <= 1'b0;
              in_gap      <= 1'b1;
              gap_cnt     <= 16'd0;
              case (state)
                S_WREN1: state <= S_ERASE;
                S_ERASE: begin state <= S_POLL1; poll_cnt <= 16'd0; end
                S_POLL1, S_POLL2: begin
                  if (wip) begin
                    if (poll_cnt == POLL_LAST) begin
                      err_code <= 3'd2;
                      in_gap   <= 1'b0;
                      state    <= S_FINISH;
                    end else begin
                      poll_cnt <= poll_cnt + 16'd1;
                    end
                  end else begin
                    state <= (state == S_POLL1) ? S_WREN2 : S_VERIFY;
                  end
                end
                S_WREN2: state <= S_PROG;
                S_PROG:  begin state <= S_POLL2; poll_cnt <= 16'd0; end
                S_VERIFY: begin
                  mismatch_cnt <= final_mm;
                  err_code     <= (final_mm != 8'd0) ? 3'd4 : 3'd0;
                  in_gap       <= 1'b0;
                  state        <= S_FINISH;
                end
                default: ;
              endcase
            end else if (wdog == WDOG_LAST) begin
              err_code    <= 3'd3;
              outstanding <= 1'b0;
              state       <= S_FINISH;
            end else begin
              wdog <= wdog + 32'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_seq.sv
// Directed bench for flash_seq: a small flash responder plus a linear list of
// update scenarios, each checked against hand-derived command logs and status.
module tb_flash_seq;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [23:0] base_addr = '0;
  logic [7:0]  seed = '0, len = '0;
  logic        flash_start;
  logic [7:0]  cmd, write_data, data_num;
  logic [23:0] addr;
  logic        flash_done = 1'b0, rd_valid = 1'b0;
  logic [7:0]  read_data = '0;
  logic        busy, done, pass;
  logic [2:0]  err_code;
  logic [7:0]  mismatch_cnt;
  logic [3:0]  dbg_state;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  // responder knobs
  int wip_left = 0;
  int stuck_wip = 0;
  int rb_n = 0;
  int bad_a = -1, bad_b = -1;
  logic [7:0] rb_val = '0;
  int hold_prog = 0;
  int in_reset_test = 0;

  logic [7:0]  cmd_q[$];
  logic [23:0] addr_q[$];
  logic [7:0]  dn_q[$];
  logic [7:0]  wd_q[$];
  int          start_q[$];
  int          done_q[$];

  flash_seq #(.GAP_CYC(GAP), .POLL_MAX(5), .TXN_TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .base_addr(base_addr), .seed(seed), .len(len),
    .flash_start(flash_start), .cmd(cmd), .addr(addr), .write_data(write_data),
    .data_num(data_num), .flash_done(flash_done), .rd_valid(rd_valid),
    .read_data(read_data), .busy(busy), .done(done), .pass(pass),
    .err_code(err_code), .mismatch_cnt(mismatch_cnt), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flash responder: 2-cycle latency, poll returns one status byte, read returns rb_n bytes
  initial begin
    logic [7:0] c, w, d;
    logic [23:0] a;
    forever begin
      @(negedge clk);
      if (flash_start === 1'b1) begin
        c = cmd; a = addr; w = write_data; d = data_num;
        cmd_q.push_back(c); addr_q.push_back(a); dn_q.push_back(d); wd_q.push_back(w);
        start_q.push_back(cyc);
        @(negedge clk);
        chk("start_pulse_width", flash_start, 1'b0);
        if (c == 8'h05) begin
          rd_valid = 1'b1;
          read_data = (stuck_wip != 0 || wip_left > 0) ? 8'h01 : 8'h00;
          if (wip_left > 0) wip_left--;
          @(negedge clk);
          rd_valid = 1'b0;
        end else if (c == 8'h03) begin
          for (int i = 0; i < rb_n; i++) begin
            rd_valid = 1'b1;
            read_data = (i == bad_a || i == bad_b) ? 8'h00 : rb_val;
            @(negedge clk);
          end
          rd_valid = 1'b0;
        end
        if (!(c == 8'h02 && hold_prog != 0)) begin
          flash_done = 1'b1;
          done_q.push_back(cyc);
          if (in_reset_test == 0)
            chk("fields_held", {cmd, addr, write_data, data_num}, {c, a, w, d});
          @(negedge clk);
          flash_done = 1'b0;
        end
      end
    end
  end

  int req_cyc;

  task automatic do_req(input logic [23:0] b, input logic [7:0] s, input logic [7:0] l);
    @(negedge clk);
    base_addr = b; seed = s; len = l; req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("done_within_budget", (at >= 0), 1'b1);
  endtask

  task automatic chk_result(input string tag, input logic p, input logic [2:0] e,
                            input logic [7:0] m);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_err"}, err_code, e);
    chk({tag, "_mm"}, mismatch_cnt, m);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int at, n0, d0, n1;
    logic [7:0]  e_cmd[10];
    logic [23:0] e_addr[10];
    logic [7:0]  e_dn[10];
    e_cmd  = '{8'h06, 8'h20, 8'h05, 8'h05, 8'h05, 8'h05, 8'h06, 8'h02, 8'h05, 8'h03};
    e_addr = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h30, 24'h0, 24'h30};
    e_dn   = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd10, 8'd1, 8'd10};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {flash_start, busy, done, pass, err_code, mismatch_cnt},
        {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0});
    chk("rst_fields", {cmd, addr, write_data, data_num}, 48'd0);
    rst_n = 1'b1;

    // normal update with 3 busy polls after erase, plus a req pulsed while busy
    wip_left = 3; rb_n = 10; rb_val = 8'hA5; bad_a = -1; bad_b = -1;
    n0 = cmd_q.size(); d0 = done_q.size();
    do_req(24'h000030, 8'hA5, 8'd10);
    chk("busy_after_accept", busy, 1'b1);
    repeat (10) @(negedge clk);
    base_addr = 24'h123456; seed = 8'h11; len = 8'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done(400, at);
    chk_result("normal", 1'b1, 3'd0, 8'd0);
    chk("normal_cmd_count", cmd_q.size() - n0, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("normal_cmd%0d", k), cmd_q[n0+k], e_cmd[k]);
      chk($sformatf("normal_addr%0d", k), addr_q[n0+k], e_addr[k]);
      chk($sformatf("normal_dn%0d", k), dn_q[n0+k], e_dn[k]);
    end
    chk("normal_prog_wd", wd_q[n0+7], 8'hA5);
    chk("first_start_latency", start_q[n0] - req_cyc, 2);
    for (int k = 1; k < 10; k++)
      chk($sformatf("gap%0d", k), start_q[n0+k] - done_q[d0+k-1], GAP + 1);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("result_held", {pass, err_code}, {1'b1, 3'd0});

    // bad lengths: range overflow, and zero length with a stray flash_done in IDLE
    n0 = cmd_q.size();
    do_req(24'h0000F8, 8'h11, 8'd9);
    wait_done(20, at);
    chk("badlen_done_latency", at - req_cyc, 3);
    chk_result("badlen", 1'b0, 3'd1, 8'd0);
    @(negedge clk);
    base_addr = 24'h0; seed = 8'h0; len = 8'd0; req = 1'b1; flash_done = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    req = 1'b0; flash_done = 1'b0;
    wait_done(20, at);
    chk("len0_done_latency", at - req_cyc, 3);
    chk_result("len0", 1'b0, 3'd1, 8'd0);
    chk("badlen_no_cmd", cmd_q.size(), n0);

    // boundary: page offset + len exactly 256 is accepted
    wip_left = 0; rb_n = 8; rb_val = 8'h5C;
    n0 = cmd_q.size();
    do_req(24'h0000F8, 8'h5C, 8'd8);
    wait_done(400, at);
    chk_result("edge256", 1'b1, 3'd0, 8'd0);
    chk("edge256_cmd_count", cmd_q.size() - n0, 7);

    // poll timeout: WIP never clears
    stuck_wip = 1;
    n0 = cmd_q.size();
    do_req(24'h001234, 8'h5A, 8'd4);
    wait_done(400, at);
    chk_result("polltmo", 1'b0, 3'd2, 8'd0);
    chk("polltmo_cmd_count", cmd_q.size() - n0, 7);
    chk("polltmo_erase_addr", addr_q[n0+1], 24'h001000);
    chk("polltmo_last_cmd", cmd_q[n0+6], 8'h05);
    stuck_wip = 0;

    // verify failures: two corrupt bytes, then two missing bytes
    rb_n = 10; rb_val = 8'h3C; bad_a = 2; bad_b = 7;
    do_req(24'h000100, 8'h3C, 8'd10);
    wait_done(400, at);
    chk_result("vfy_corrupt", 1'b0, 3'd4, 8'd2);
    rb_n = 8; bad_a = -1; bad_b = -1;
    do_req(24'h000100, 8'h3C, 8'd10);
    wait_done(400, at);
    chk_result("vfy_short", 1'b0, 3'd4, 8'd2);
    rb_n = 12;
    do_req(24'h000100, 8'h3C, 8'd10);
    wait_done(400, at);
    chk_result("vfy_extra", 1'b1, 3'd0, 8'd0);

    // transaction timeout: no flash_done for PROG
    hold_prog = 1;
    n0 = cmd_q.size();
    do_req(24'h000040, 8'h77, 8'd4);
    wait_done(400, at);
    chk("txntmo_prog_cmd", cmd_q[n0+4], 8'h02);
    chk("txntmo_latency", at - start_q[n0+4], 51);
    chk_result("txntmo", 1'b0, 3'd3, 8'd0);
    chk("txntmo_cmd_count", cmd_q.size() - n0, 5);
    hold_prog = 0;

    // reset while the erase command is outstanding
    wip_left = 0;
    do_req(24'h002000, 8'h11, 8'd4);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (flash_start === 1'b1 && cmd === 8'h20) begin
        at = cyc;
        break;
      end
    end
    chk("erase_reached", (at >= 0), 1'b1);
    in_reset_test = 1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {flash_start, busy, done, pass, err_code, mismatch_cnt},
        {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0});
    chk("midrst_fields", {cmd, addr, write_data, data_num}, 48'd0);
    rst_n = 1'b1;
    n1 = cmd_q.size();
    repeat (60) @(negedge clk);
    chk("midrst_no_cmd", cmd_q.size(), n1);
    chk("midrst_idle", {busy, done}, 2'b00);
    in_reset_test = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
